// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, FSM encodings, lane masks,
// the latched request record and the access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Only the low two bits carry the width; 011/11x fall through to word.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case ({1'b0, f3[1:0]})
      F3_B:    return SZ_BYTE;
      F3_H:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave):
// single-outstanding req/gnt for the address phase, rvalid for read data.
interface lsu_if;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication and byte mask on the way out,
// load word shift and sign/zero extension on the way back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wmask_o,
  output logic [31:0] load_data_o
);

  lsu_size_e   w_size;
  logic        w_unsigned;
  logic [31:0] w_shifted;

  assign w_size     = f3_size(funct3_i);
  assign w_unsigned = (funct3_i == F3_BU) || (funct3_i == F3_HU);
  assign w_shifted  = load_word_i >> {offset_i, 3'b000};

  always_comb begin
    // NOTE: every output is defaulted first so no path through the case leaves a latch.
    wdata_o     = store_data_i;
    wmask_o     = LANE_W;
    load_data_o = w_shifted;
    case (w_size)
      SZ_BYTE: begin
        wdata_o     = {4{store_data_i[7:0]}};
        wmask_o     = LANE_B << offset_i;
        load_data_o = {{24{w_shifted[7] & ~w_unsigned}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        wdata_o     = {2{store_data_i[15:0]}};
        wmask_o     = LANE_H << {offset_i[1], 1'b0};
        load_data_o = {{16{w_shifted[15] & ~w_unsigned}}, w_shifted[15:0]};
      end
      default: ;
    endcase
    if (!we_i) wmask_o = '0;
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding data-memory transaction with timeout.
// Define LSU_MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  lsu_if.master       mem,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]    r_state;
  lsu_req_t      r_req;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic          r_err;

  lsu_size_e     w_size;
  logic [31:0]   w_addr_eff;
  logic          w_trap;
  logic          w_timeout;
  logic [31:0]   w_load_data;

  assign w_size = f3_size(req_funct3_i);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_addr_eff = req_addr_i;
  assign w_trap     = ((w_size == SZ_HALF) && req_addr_i[0]) ||
                      ((w_size == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
  // Misaligned halves/words are silently pulled down to their natural boundary.
  always_comb begin
    w_addr_eff = req_addr_i;
    case (w_size)
      SZ_HALF: w_addr_eff[0]   = 1'b0;
      SZ_WORD: w_addr_eff[1:0] = 2'b00;
      default: ;
    endcase
  end
  assign w_trap = 1'b0;
`endif

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

  lsu_align u_align (
    .funct3_i     (r_req.funct3),
    .we_i         (r_req.we),
    .offset_i     (r_req.addr[1:0]),
    .store_data_i (r_req.wdata),
    .load_word_i  (mem.mem_rdata_i),
    .wdata_o      (mem.mem_wdata_o),
    .wmask_o      (mem.mem_wmask_o),
    .load_data_o  (w_load_data)
  );

  assign req_ready_o    = (r_state == ST_IDLE);
  assign mem.mem_req_o  = (r_state == ST_REQ);
  assign mem.mem_we_o   = r_req.we;
  assign mem.mem_addr_o = {r_req.addr[31:2], 2'b00};
  assign rsp_valid_o    = (r_state == ST_RESP);
  assign rsp_rdata_o    = r_rdata;
  assign rsp_err_o      = r_err;

  // NOTE: all sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_req <= '{we: req_we_i, funct3: req_funct3_i, addr: w_addr_eff, wdata: req_wdata_i};
            r_cnt <= '0;
            if (w_trap) begin
              r_state <= ST_RESP;
              r_rdata <= '0;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt_i) begin
            r_cnt <= '0;
            if (r_req.we) begin
              r_state <= ST_RESP;
              r_rdata <= '0;
              r_err   <= 1'b0;
            end else begin
              r_state <= ST_WAIT;
            end
          end else if (w_timeout) begin
            r_state <= ST_RESP;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (mem.mem_rvalid_i) begin
            r_state <= ST_RESP;
            r_rdata <= w_load_data;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_state <= ST_RESP;
            r_rdata <= '0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a hand-driven memory and TIMEOUT_CYCLES=4.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .mem          (mem_bus),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request in an IDLE cycle; returns in the first cycle after acceptance.
  task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    step();
    req_valid_i  = 1'b0;
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_mask);
    accept(1'b1, f3, addr, wdata);
    check("st_req", mem_bus.mem_req_o, 1);
    check("st_we", mem_bus.mem_we_o, 1);
    check("st_addr", mem_bus.mem_addr_o, exp_addr);
    check("st_wdata", mem_bus.mem_wdata_o, exp_wdata);
    check("st_wmask", mem_bus.mem_wmask_o, exp_mask);
    check("st_no_rsp_yet", rsp_valid_o, 0);
    mem_bus.mem_gnt_i = 1'b1;
    step();
    mem_bus.mem_gnt_i = 1'b0;
    check("st_rsp_valid", rsp_valid_o, 1);
    check("st_rsp_err", rsp_err_o, 0);
    check("st_rsp_rdata", rsp_rdata_o, 0);
    check("st_req_dropped", mem_bus.mem_req_o, 0);
    step();
    check("st_rsp_pulse_end", rsp_valid_o, 0);
    check("st_ready_again", req_ready_o, 1);
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                          input logic [31:0] exp_addr, input logic [31:0] exp_data);
    accept(1'b0, f3, addr, 32'h0);
    check("ld_req", mem_bus.mem_req_o, 1);
    check("ld_we", mem_bus.mem_we_o, 0);
    check("ld_addr", mem_bus.mem_addr_o, exp_addr);
    check("ld_wmask", mem_bus.mem_wmask_o, 0);
    mem_bus.mem_gnt_i = 1'b1;
    step();
    mem_bus.mem_gnt_i = 1'b0;
    check("ld_wait_no_rsp", rsp_valid_o, 0);
    check("ld_wait_no_req", mem_bus.mem_req_o, 0);
    mem_bus.mem_rvalid_i = 1'b1;
    mem_bus.mem_rdata_i  = word;
    step();
    mem_bus.mem_rvalid_i = 1'b0;
    check("ld_rsp_valid", rsp_valid_o, 1);
    check("ld_rsp_rdata", rsp_rdata_o, exp_data);
    check("ld_rsp_err", rsp_err_o, 0);
    step();
    check("ld_rsp_pulse_end", rsp_valid_o, 0);
  endtask

  initial begin
    reset_i              = 1'b1;
    req_valid_i          = 1'b0;
    req_we_i             = 1'b0;
    req_funct3_i         = 3'b000;
    req_addr_i           = 32'h0;
    req_wdata_i          = 32'h0;
    mem_bus.mem_gnt_i    = 1'b0;
    mem_bus.mem_rvalid_i = 1'b0;
    mem_bus.mem_rdata_i  = 32'h0;
    step();
    step();
    check("rst_mem_req", mem_bus.mem_req_o, 0);
    check("rst_mem_we", mem_bus.mem_we_o, 0);
    check("rst_mem_addr", mem_bus.mem_addr_o, 0);
    check("rst_mem_wmask", mem_bus.mem_wmask_o, 0);
    check("rst_mem_wdata", mem_bus.mem_wdata_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_rdata", rsp_rdata_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    reset_i = 1'b0;
    step();
    check("rst_ready", req_ready_o, 1);

    // Stores: word, half with replication, byte lane, funct3 bit 2 ignored.
    run_store(F3_W,   32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
    run_store(F3_H,   32'h0000_0202, 32'h0000_ABCD, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100);
    run_store(F3_B,   32'h0000_0101, 32'h1234_5678, 32'h0000_0100, 32'h7878_7878, 4'b0010);
    run_store(3'b101, 32'h0000_0200, 32'h1234_5678, 32'h0000_0200, 32'h5678_5678, 4'b0011);
    run_store(3'b110, 32'h0000_0304, 32'hA5A5_0F0F, 32'h0000_0304, 32'hA5A5_0F0F, 4'b1111);

    // Loads: sign/zero extension across lanes; 111 decodes as a word.
    run_load(F3_B,   32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0100, 32'hFFFF_FF80);
    run_load(F3_BU,  32'h0000_0103, 32'h80FF_FFFF, 32'h0000_0100, 32'h0000_0080);
    run_load(F3_H,   32'h0000_0102, 32'h8001_1234, 32'h0000_0100, 32'hFFFF_8001);
    run_load(F3_HU,  32'h0000_0102, 32'h8001_1234, 32'h0000_0100, 32'h0000_8001);
    run_load(F3_B,   32'h0000_0100, 32'h1234_5677, 32'h0000_0100, 32'h0000_0077);
    run_load(3'b111, 32'h0000_0104, 32'hCAFE_F00D, 32'h0000_0104, 32'hCAFE_F00D);

    // LW with gnt on the fourth REQ cycle and rvalid on the third WAIT cycle.
    accept(1'b0, F3_W, 32'h0000_0300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("stall_req_held", mem_bus.mem_req_o, 1);
      check("stall_addr_stable", mem_bus.mem_addr_o, 32'h0000_0300);
      check("stall_no_rsp", rsp_valid_o, 0);
      if (i == 3) mem_bus.mem_gnt_i = 1'b1;
      step();
    end
    mem_bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_wait_no_req", mem_bus.mem_req_o, 0);
      check("stall_wait_no_rsp", rsp_valid_o, 0);
      if (i == 2) begin
        mem_bus.mem_rvalid_i = 1'b1;
        mem_bus.mem_rdata_i  = 32'h1357_9BDF;
      end
      step();
    end
    mem_bus.mem_rvalid_i = 1'b0;
    check("stall_rsp_valid", rsp_valid_o, 1);
    check("stall_rsp_rdata", rsp_rdata_o, 32'h1357_9BDF);
    step();
    check("stall_single_pulse", rsp_valid_o, 0);

    // Grant never arrives: error after four REQ cycles, late rvalid ignored.
    accept(1'b0, F3_W, 32'h0000_0400, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", mem_bus.mem_req_o, 1);
      check("to_no_rsp", rsp_valid_o, 0);
      step();
    end
    check("to_rsp_valid", rsp_valid_o, 1);
    check("to_rsp_err", rsp_err_o, 1);
    check("to_rsp_rdata", rsp_rdata_o, 0);
    check("to_req_dropped", mem_bus.mem_req_o, 0);
    mem_bus.mem_rvalid_i = 1'b1;
    mem_bus.mem_rdata_i  = 32'hFFFF_FFFF;
    step();
    check("to_late_rvalid_no_rsp", rsp_valid_o, 0);
    check("to_ready", req_ready_o, 1);
    step();
    mem_bus.mem_rvalid_i = 1'b0;
    check("to_late_rvalid_still_idle", rsp_valid_o, 0);

    // Granted but rvalid never arrives: error after four WAIT cycles.
    accept(1'b0, F3_W, 32'h0000_0408, 32'h0);
    mem_bus.mem_gnt_i = 1'b1;
    step();
    mem_bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_wait_no_rsp", rsp_valid_o, 0);
      step();
    end
    check("to_wait_rsp_valid", rsp_valid_o, 1);
    check("to_wait_rsp_err", rsp_err_o, 1);
    step();

    // Misaligned word load.
    accept(1'b0, F3_W, 32'h0000_0101, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_no_req", mem_bus.mem_req_o, 0);
    check("mis_rsp_valid", rsp_valid_o, 1);
    check("mis_rsp_err", rsp_err_o, 1);
    check("mis_rsp_rdata", rsp_rdata_o, 0);
    step();
    check("mis_ready", req_ready_o, 1);
`else
    check("mis_req", mem_bus.mem_req_o, 1);
    check("mis_addr_aligned", mem_bus.mem_addr_o, 32'h0000_0100);
    mem_bus.mem_gnt_i = 1'b1;
    step();
    mem_bus.mem_gnt_i    = 1'b0;
    mem_bus.mem_rvalid_i = 1'b1;
    mem_bus.mem_rdata_i  = 32'hCAFE_F00D;
    step();
    mem_bus.mem_rvalid_i = 1'b0;
    check("mis_rsp_valid", rsp_valid_o, 1);
    check("mis_rsp_err", rsp_err_o, 0);
    check("mis_rsp_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    step();
`endif

    // Reset while in WAIT abandons the load with no response.
    accept(1'b0, F3_W, 32'h0000_0500, 32'h0);
    mem_bus.mem_gnt_i = 1'b1;
    step();
    mem_bus.mem_gnt_i    = 1'b0;
    reset_i              = 1'b1;
    mem_bus.mem_rvalid_i = 1'b1;
    mem_bus.mem_rdata_i  = 32'h1111_2222;
    step();
    reset_i              = 1'b0;
    check("rstw_no_rsp", rsp_valid_o, 0);
    check("rstw_ready", req_ready_o, 1);
    step();
    mem_bus.mem_rvalid_i = 1'b0;
    check("rstw_still_no_rsp", rsp_valid_o, 0);
    check("rstw_no_req", mem_bus.mem_req_o, 0);
    step();
    check("rstw_idle", req_ready_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
